// File: rtl/axi_id_ctrl_pkg.sv
// Shared types for the AXI ID issue controller.
// The beat-hold struct depends on the ID/select widths, so it is typedef'd inside the module.
package axi_id_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ISSUE      = 2'd1,
      ISSUE_ATOP = 2'd2
   } id_ctrl_state_e;

endpackage

// File: rtl/axi_id_issue_ctrl.sv
// Per-direction Ax issue controller: admits beats that keep AXI same-ID ordering, registers
// them toward the master mux, and drives push/pop of the neighbouring ID in-flight table.
module axi_id_issue_ctrl
   import axi_id_ctrl_pkg::*;
#(
   parameter int unsigned IdWidth     = 4,
   parameter int unsigned AxiLookBits = 3,
   parameter int unsigned SelWidth    = 2,
   parameter int unsigned CntWidth    = 4,
   parameter int unsigned MaxTrans    = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   slv_ax_valid_i,
   output logic                   slv_ax_ready_o,
   input  logic [IdWidth-1:0]     slv_ax_id_i,
   input  logic [SelWidth-1:0]    slv_ax_sel_i,
   input  logic                   slv_ax_atomic_i,
   output logic                   mst_ax_valid_o,
   input  logic                   mst_ax_ready_i,
   output logic [IdWidth-1:0]     mst_ax_id_o,
   output logic [SelWidth-1:0]    mst_ax_sel_o,
   output logic [AxiLookBits-1:0] tbl_lookup_id_o,
   input  logic [SelWidth-1:0]    tbl_lookup_sel_i,
   input  logic                   tbl_lookup_taken_i,
   output logic [AxiLookBits-1:0] tbl_atomic_id_o,
   input  logic                   tbl_atomic_taken_i,
   input  logic [CntWidth-1:0]    tbl_cnt_i,
   output logic                   tbl_push_en_o,
   output logic [AxiLookBits-1:0] tbl_push_id_o,
   output logic [SelWidth-1:0]    tbl_push_sel_o,
   output logic                   tbl_atomic_push_o,
   input  logic                   rsp_valid_i,
   input  logic                   rsp_ready_i,
   input  logic                   rsp_last_i,
   input  logic [IdWidth-1:0]     rsp_id_i,
   output logic                   tbl_pop_en_o,
   output logic [AxiLookBits-1:0] tbl_pop_id_o,
   output logic                   stall_o,
   output logic                   err_o
);

   typedef struct packed {
      logic [IdWidth-1:0]  id;
      logic [SelWidth-1:0] sel;
   } ax_hold_t;

   if (AxiLookBits > IdWidth) begin : g_bad_look
      $error("AxiLookBits must not exceed IdWidth");
   end
   if (MaxTrans >= (1 << CntWidth)) begin : g_bad_max
      $error("MaxTrans must be below 2**CntWidth");
   end

   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTrans);

   id_ctrl_state_e state_q, state_d;
   ax_hold_t       hold_q;
   logic           err_q;
   logic           legal;
   logic           accept;
   logic           pop;
   logic           unused_rsp_id;

   // Upper ID bits alias onto the same table slot; that is conservative but legal.
   assign tbl_lookup_id_o = slv_ax_id_i[AxiLookBits-1:0];
   assign tbl_atomic_id_o = slv_ax_id_i[AxiLookBits-1:0];
   assign tbl_push_id_o   = slv_ax_id_i[AxiLookBits-1:0];
   assign tbl_push_sel_o  = slv_ax_sel_i;
   assign tbl_pop_id_o    = rsp_id_i[AxiLookBits-1:0];
   assign unused_rsp_id   = ^rsp_id_i;

   assign legal = !(tbl_lookup_taken_i && (tbl_lookup_sel_i != slv_ax_sel_i))
                  && (tbl_cnt_i < MaxCnt)
                  && !(slv_ax_atomic_i && tbl_atomic_taken_i);

   always_comb begin
      state_d        = state_q;
      slv_ax_ready_o = 1'b0;
      mst_ax_valid_o = 1'b0;
      case (state_q)
         IDLE: slv_ax_ready_o = legal;
         ISSUE: begin
            mst_ax_valid_o = 1'b1;
            // An atomic behind a plain beat must wait for IDLE so it issues alone.
            slv_ax_ready_o = mst_ax_ready_i && legal && !slv_ax_atomic_i;
            if (mst_ax_ready_i) state_d = IDLE;
         end
         ISSUE_ATOP: begin
            mst_ax_valid_o = 1'b1;
            if (mst_ax_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst_i) begin
         slv_ax_ready_o = 1'b0;
         mst_ax_valid_o = 1'b0;
      end
      accept = slv_ax_valid_i && slv_ax_ready_o;
      if (accept) state_d = slv_ax_atomic_i ? ISSUE_ATOP : ISSUE;
   end

   // Push at accept so a beat still sitting in the output register is already visible.
   assign tbl_push_en_o     = accept;
   assign tbl_atomic_push_o = accept && slv_ax_atomic_i;
   assign pop               = !rst_i && rsp_valid_i && rsp_ready_i && rsp_last_i;
   assign tbl_pop_en_o      = pop;
   assign stall_o           = !rst_i && slv_ax_valid_i && !slv_ax_ready_o
                              && ((state_q == IDLE) || mst_ax_ready_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         hold_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) hold_q <= '{id: slv_ax_id_i, sel: slv_ax_sel_i};
         if (pop && (tbl_cnt_i == '0)) err_q <= 1'b1;
      end
   end

   assign mst_ax_id_o  = hold_q.id;
   assign mst_ax_sel_o = hold_q.sel;
   assign err_o        = err_q;

endmodule
